pulse_width_encoder: RTL and testbench

Byte-serial pulse-width transmitter: the transmit end of the single-wire pulse-length protocol consumed by our input timer decoder. Each accepted byte is sent MSB-first as eight high pulses: a short pulse encodes 0, a long pulse encodes 1, and each pulse is followed by a fixed low gap. The block sits between the byte-level datapath (valid/ready source) and the output pad driving `digital_out`.

---
 rtl/pulse_width_encoder_if.sv | 18 +
 rtl/pulse_width_encoder.sv | 101 ++++++++++
 tb/tb_pulse_width_encoder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/pulse_width_encoder_if.sv
// Byte handshake between the datapath source and the pulse-width transmitter.
interface pulse_width_encoder_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/pulse_width_encoder.sv
// Byte-serial pulse-width transmitter: each byte goes out MSB-first as eight
// high pulses (short = 0, long = 1), every pulse followed by a fixed low gap.
module pulse_width_encoder #(
  parameter int SHORT_HIGH = 9,
  parameter int LONG_HIGH  = 18,
  parameter int LOW_GAP    = 9
) (
  input  logic                   clock,
  input  logic                   reset,
  pulse_width_encoder_if.slave   dataIf,
  output logic                   busy,
  output logic                   digital_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  // Counters run down to zero, so every load is the duration minus one.
  localparam logic [7:0] SHORT_LOAD = 8'(SHORT_HIGH - 1);
  localparam logic [7:0] LONG_LOAD  = 8'(LONG_HIGH - 1);
  localparam logic [7:0] GAP_LOAD   = 8'(LOW_GAP - 1);

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [7:0] r_shreg;
  logic [2:0] r_bitsLeft;
  logic       r_digitalOut;

  state_t     w_stateNext;
  logic [7:0] w_cntNext;
  logic [7:0] w_shregNext;
  logic [2:0] w_bitsLeftNext;
  logic [7:0] w_shifted;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_shreg      <= '0;
      r_bitsLeft   <= '0;
      r_digitalOut <= 1'b0;
    end else begin
      r_state      <= w_stateNext;
      r_cnt        <= w_cntNext;
      r_shreg      <= w_shregNext;
      r_bitsLeft   <= w_bitsLeftNext;
      r_digitalOut <= (w_stateNext == HIGH);
    end
  end

  always_comb begin
    w_stateNext    = r_state;
    w_cntNext      = r_cnt;
    w_shregNext    = r_shreg;
    w_bitsLeftNext = r_bitsLeft;
    w_shifted      = {r_shreg[6:0], 1'b0};

    unique case (r_state)
      IDLE: begin
        if (dataIf.data_valid) begin
          w_shregNext    = dataIf.data_in;
          w_bitsLeftNext = 3'd7;
          w_cntNext      = dataIf.data_in[7] ? LONG_LOAD : SHORT_LOAD;
          w_stateNext    = HIGH;
        end
      end
      HIGH: begin
        if (r_cnt != 8'd0) begin
          w_cntNext = r_cnt - 8'd1;
        end else begin
          w_cntNext   = GAP_LOAD;
          w_stateNext = LOW;
        end
      end
      LOW: begin
        if (r_cnt != 8'd0) begin
          w_cntNext = r_cnt - 8'd1;
        end else if (r_bitsLeft != 3'd0) begin
          // The width of the next pulse comes from the bit just shifted into the MSB.
          w_shregNext    = w_shifted;
          w_bitsLeftNext = r_bitsLeft - 3'd1;
          w_cntNext      = w_shifted[7] ? LONG_LOAD : SHORT_LOAD;
          w_stateNext    = HIGH;
        end else begin
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  assign dataIf.data_ready = (r_state == IDLE);
  assign busy              = (r_state != IDLE);
  assign digital_out       = r_digitalOut;

endmodule

// File: tb/tb_pulse_width_encoder.sv
// Bench for pulse_width_encoder: a per-cycle waveform model plus measured pulse
// widths and byte durations checked against hand-computed values.
module tb_pulse_width_encoder;

  localparam int SHORT = 9;
  localparam int LONG  = 18;
  localparam int GAP   = 9;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic busy;
  logic digitalOut;

  int vecCount  = 0;
  int missCount = 0;

  pulse_width_encoder_if dataIf ();

  pulse_width_encoder #(
    .SHORT_HIGH(SHORT),
    .LONG_HIGH (LONG),
    .LOW_GAP   (GAP)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .dataIf     (dataIf),
    .busy       (busy),
    .digital_out(digitalOut)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vecCount++;
    if (actual != expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Model: an accepted byte expands into its whole line waveform, one entry per
  // cycle; the block is busy exactly while entries remain.
  logic modelQ[$];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      modelQ.delete();
    end else if (modelQ.size() != 0) begin
      modelQ.delete(0);
    end else if (dataIf.data_valid) begin
      for (int b = 7; b >= 0; b--) begin
        int hi;
        hi = dataIf.data_in[b] ? LONG : SHORT;
        repeat (hi) modelQ.push_back(1'b1);
        repeat (GAP) modelQ.push_back(1'b0);
      end
    end
  end

  always @(negedge clock) begin
    int expOut;
    expOut = (modelQ.size() != 0) ? int'(modelQ[0]) : 0;
    checkOutput("digital_out", int'(digitalOut), expOut);
    checkOutput("data_ready", int'(dataIf.data_ready), int'(modelQ.size() == 0));
    checkOutput("busy", int'(busy), int'(modelQ.size() != 0));
  end

  // Measures high-run lengths and the low runs that sit between two pulses.
  logic prevOut;
  int   runLen;
  bit   sawHigh;
  int   highQ[$];
  int   lowQ[$];

  always @(negedge clock or posedge reset) begin
    if (reset) begin
      prevOut = 1'b0;
      runLen  = 0;
      sawHigh = 1'b0;
    end else if (digitalOut == prevOut) begin
      runLen++;
    end else begin
      if (prevOut) begin
        highQ.push_back(runLen);
        sawHigh = 1'b1;
      end else if (sawHigh) begin
        lowQ.push_back(runLen);
      end
      runLen  = 1;
      prevOut = digitalOut;
    end
  end

  task automatic clearMonitor();
    highQ.delete();
    lowQ.delete();
    sawHigh = 1'b0;
  endtask

  task automatic waitIdle(input bit scramble, output int busyCycles);
    int guard;
    busyCycles = 0;
    guard      = 0;
    while (busy && guard < 400) begin
      busyCycles++;
      guard++;
      if (scramble) begin
        dataIf.data_in    = 8'hFF;
        dataIf.data_valid = ~dataIf.data_valid;
      end
      @(negedge clock);
    end
    if (scramble) dataIf.data_valid = 1'b0;
    if (guard >= 400) checkOutput("idle timeout", 1, 0);
  endtask

  task automatic checkWidths(input string name, input int first, input int expW[8]);
    if (highQ.size() < first + 8) begin
      checkOutput({name, " count"}, highQ.size(), first + 8);
    end else begin
      for (int i = 0; i < 8; i++) checkOutput(name, highQ[first + i], expW[i]);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit scramble,
                               input int expBusy, input int expW[8]);
    int cycles;
    @(negedge clock);
    clearMonitor();
    dataIf.data_in    = b;
    dataIf.data_valid = 1'b1;
    @(negedge clock);
    dataIf.data_valid = 1'b0;
    waitIdle(scramble, cycles);
    checkOutput("byte duration", cycles, expBusy);
    checkWidths("pulse width", 0, expW);
  endtask

  initial begin
    int cycles;
    dataIf.data_in    = 8'hAA;
    dataIf.data_valid = 1'b0;

    // Reset asserted between edges, with a byte offered throughout.
    #1 reset = 1'b1;
    dataIf.data_valid = 1'b1;
    #1;
    checkOutput("reset digital_out", int'(digitalOut), 0);
    checkOutput("reset data_ready", int'(dataIf.data_ready), 1);
    checkOutput("reset busy", int'(busy), 0);
    repeat (3) @(negedge clock);
    checkOutput("held reset busy", int'(busy), 0);
    reset             = 1'b0;
    dataIf.data_valid = 1'b0;
    repeat (2) @(negedge clock);

    $display("[TB] byte 0x00");
    applyStimulus(8'h00, 1'b0, 144, '{9, 9, 9, 9, 9, 9, 9, 9});
    for (int i = 0; i < 7; i++) checkOutput("gap 0x00", lowQ[i], 9);

    $display("[TB] byte 0xA5");
    applyStimulus(8'hA5, 1'b0, 180, '{18, 9, 18, 9, 9, 18, 9, 18});

    $display("[TB] byte 0x3C with inputs disturbed mid-byte");
    applyStimulus(8'h3C, 1'b1, 180, '{9, 9, 18, 18, 18, 18, 9, 9});

    $display("[TB] back-to-back 0xFF then 0x01");
    @(negedge clock);
    clearMonitor();
    dataIf.data_in    = 8'hFF;
    dataIf.data_valid = 1'b1;
    @(negedge clock);
    dataIf.data_in = 8'h01;
    waitIdle(1'b0, cycles);
    checkOutput("duration 0xFF", cycles, 216);
    @(negedge clock);
    dataIf.data_valid = 1'b0;
    waitIdle(1'b0, cycles);
    checkOutput("duration 0x01", cycles, 153);
    checkWidths("width 0xFF", 0, '{18, 18, 18, 18, 18, 18, 18, 18});
    checkWidths("width 0x01", 8, '{9, 9, 9, 9, 9, 9, 9, 18});
    checkOutput("gap count", lowQ.size(), 15);
    if (lowQ.size() > 7) checkOutput("inter-byte gap", lowQ[7], 10);

    $display("[TB] reset during fourth pulse of 0xFF");
    @(negedge clock);
    clearMonitor();
    dataIf.data_in    = 8'hFF;
    dataIf.data_valid = 1'b1;
    @(negedge clock);
    dataIf.data_valid = 1'b0;
    repeat (86) @(negedge clock);
    checkOutput("pulse 3 high", int'(digitalOut), 1);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    checkOutput("async drop digital_out", int'(digitalOut), 0);
    checkOutput("async data_ready", int'(dataIf.data_ready), 1);
    checkOutput("async busy", int'(busy), 0);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(8'h80, 1'b0, 153, '{18, 9, 9, 9, 9, 9, 9, 9});

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
